// File: rtl/rst_clk_sched_if.sv
// Soft-reset handshake, divider control and sequenced reset outputs
// of the reset/clock-enable scheduler.
`timescale 1ns/1ps
interface rst_clk_sched_if #(
    parameter int G_NB_RST    = 4,
    parameter int G_DIV_WIDTH = 16
);
    logic                   soft_rst_req;
    logic                   soft_rst_ack;
    logic [G_DIV_WIDTH-1:0] div_val;
    logic [G_NB_RST-1:0]    o_rst_n;
    logic                   o_clk_en;
    logic                   o_ready;

    modport master (
        output soft_rst_req,
        output div_val,
        input  soft_rst_ack,
        input  o_rst_n,
        input  o_clk_en,
        input  o_ready
    );

    modport slave (
        input  soft_rst_req,
        input  div_val,
        output soft_rst_ack,
        output o_rst_n,
        output o_clk_en,
        output o_ready
    );
endinterface

// File: rtl/rst_clk_sched.sv
// Staggered reset release for G_NB_RST domains, soft-reset handshake
// and a programmable clock-enable divider once all domains run.
`timescale 1ns/1ps
module rst_clk_sched #(
    parameter int G_NB_RST      = 4,
    parameter int G_STAGGER     = 8,
    parameter int G_SYNC_STAGES = 2,
    parameter int G_DIV_WIDTH   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    rst_clk_sched_if.slave bus
);
    localparam int CW = $clog2(G_STAGGER);
    localparam int IW = (G_NB_RST > 1) ? $clog2(G_NB_RST) : 1;
    localparam logic [CW-1:0] C_TERM = CW'(G_STAGGER - 1);
    localparam logic [IW-1:0] C_LAST = IW'(G_NB_RST - 1);
    localparam logic [G_NB_RST-1:0] C_ONE = G_NB_RST'(1);

    typedef enum logic [1:0] {
        S_RESET,
        S_RELEASE,
        S_RUN,
        S_SOFT_HOLD
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [G_NB_RST-1:0]      rst_q, rst_d;
    logic                     rdy_q, rdy_d;
    logic                     en_q, en_d;
    logic                     ack_q, ack_d;
    logic                     req_q;
    logic [G_DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic [G_DIV_WIDTH-1:0]   div_lat_q, div_lat_d;
    logic [G_SYNC_STAGES-1:0] sync_q;
    logic                     rst_sync;
    logic                     req_edge;

    assign rst_sync = sync_q[G_SYNC_STAGES-1];
    assign req_edge = bus.soft_rst_req & ~req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[G_SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_q     <= '0;
            rdy_q     <= 1'b0;
            en_q      <= 1'b0;
            ack_q     <= 1'b0;
            req_q     <= 1'b0;
            div_cnt_q <= '0;
            div_lat_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_q     <= rst_d;
            rdy_q     <= rdy_d;
            en_q      <= en_d;
            ack_q     <= ack_d;
            req_q     <= bus.soft_rst_req;
            div_cnt_q <= div_cnt_d;
            div_lat_q <= div_lat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_d     = rst_q;
        rdy_d     = rdy_q;
        en_d      = en_q;
        ack_d     = 1'b0;
        div_cnt_d = div_cnt_q;
        div_lat_d = div_lat_q;
        unique case (state_q)
            S_RESET: begin
                if (rst_sync) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_RELEASE: begin
                if (cnt_q == C_TERM) begin
                    cnt_d = '0;
                    rst_d = rst_q | (C_ONE << idx_q);
                    idx_d = idx_q + IW'(1);
                    if (idx_q == C_LAST) begin
                        // Divider starts at zero so the first run cycle pulses
                        state_d   = S_RUN;
                        rdy_d     = 1'b1;
                        en_d      = 1'b1;
                        idx_d     = '0;
                        div_cnt_d = '0;
                        div_lat_d = bus.div_val;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (req_edge) begin
                    state_d   = S_SOFT_HOLD;
                    cnt_d     = '0;
                    rst_d     = '0;
                    rdy_d     = 1'b0;
                    en_d      = 1'b0;
                    div_cnt_d = '0;
                end else if (div_cnt_q == div_lat_q) begin
                    div_cnt_d = '0;
                    div_lat_d = bus.div_val;
                    en_d      = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + G_DIV_WIDTH'(1);
                    en_d      = 1'b0;
                end
            end
            S_SOFT_HOLD: begin
                if (cnt_q == C_TERM) begin
                    state_d = S_RELEASE;
                    ack_d   = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    assign bus.o_rst_n      = rst_q;
    assign bus.o_ready      = rdy_q;
    assign bus.o_clk_en     = en_q;
    assign bus.soft_rst_ack = ack_q;
endmodule

// File: doc/rst_clk_sched.md
# rst_clk_sched

Reset and clock-enable scheduler for the simulation/bench clocking infrastructure. Takes the single clock and raw active-low reset produced by the bench clock/reset generator and releases reset to G_NB_RST downstream domains one after another, with a programmable stagger. Once every domain is out of reset, it produces a programmable-rate clock-enable pulse for slow logic. A soft-reset request/acknowledge handshake lets a bench sequencer re-run the release sequence without toggling the hard reset.

## Interface
Parameters:
- G_NB_RST, 4: number of sequenced reset domains (1..16).
- G_STAGGER, 8: cycles between successive domain releases; also the soft-reset hold time (≥2).
- G_SYNC_STAGES, 2: reset-deassertion synchronizer depth (≥2).
- G_DIV_WIDTH, 16: width of div_val.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset; asynchronous, active-low. Assertion acts immediately. Deassertion is synchronized internally.
- soft_rst_req  in  1  soft-reset request, level; acted on at its rising edge.
- div_val  in  G_DIV_WIDTH  clock-enable divider value.
- soft_rst_ack  out  1  one-cycle acknowledge pulse.
- o_rst_n  out  G_NB_RST  per-domain active-low resets; bit k is released k-th.
- o_clk_en  out  1  clock-enable pulse.
- o_ready  out  1  high when all domains are released and the block is in S_RUN.

## Operation
- All outputs are registered.
- Reset values: o_rst_n all 0, o_clk_en 0, o_ready 0, soft_rst_ack 0. State S_RESET, counters 0, edge-detect register 0.
- Synchronizer: G_SYNC_STAGES flops are cleared asynchronously by rst_n and shift in 1 afterwards. rst_sync is the last stage.
- FSM states:
  - S_RESET: wait for rst_sync=1, then go to S_RELEASE with stagger count 0 and domain index 0.
  - S_RELEASE: the stagger counter runs 0..G_STAGGER-1. At the terminal count, set o_rst_n[idx]=1, increment idx, and clear the counter. Released bits stay high. When idx = G_NB_RST-1 is released, assert o_ready in the same update and go to S_RUN.
  - S_RUN: on a rising edge of soft_rst_req (req=1 and registered previous req=0), clear all o_rst_n, o_ready and o_clk_en in the same update, then go to S_SOFT_HOLD with the counter at 0.
  - S_SOFT_HOLD: hold all resets low for G_STAGGER cycles. At the terminal count, pulse soft_rst_ack for exactly one cycle, then enter S_RELEASE with counter and idx at 0.
- Soft-request rules:
  - Rising edges of soft_rst_req outside S_RUN are ignored; they are not latched and produce no ack.
  - A req held high across a hard reset or across ack does not retrigger; it must go low, then high again.
  - The edge-detect register updates in every state.
- Clock-enable divider:
  - Active only in S_RUN. The counter is 0 on entry to S_RUN and counts 0..div_val, then wraps to 0.
  - o_clk_en=1 in every S_RUN cycle where the counter is 0. With div_val=0, o_clk_en stays high continuously.
  - div_val is sampled only at wrap; a change takes effect from the next period.
  - Leaving S_RUN clears the counter and o_clk_en.
- Hard reset at any time, including mid-release and mid-hold, returns all outputs to their reset values asynchronously. A sequence in progress is abandoned.

## Timing
- Deassertion latency: rst_n rises between edges E0 and E1. rst_sync is 1 after E(G_SYNC_STAGES). The FSM is in S_RELEASE from the following edge; call that first S_RELEASE cycle T0.
- o_rst_n[k] reads 1 from cycle T0+(k+1)·G_STAGGER.
- o_ready and o_clk_en rise together with o_rst_n[G_NB_RST-1] at T0+G_NB_RST·G_STAGGER.
- Soft reset:
  - The req rising edge is sampled at cycle Ts in S_RUN. Resets and o_ready read 0 from Ts+1.
  - soft_rst_ack is high during cycle Ts+G_STAGGER+1 only, which is also T0 of the new release sequence.
- o_clk_en period is div_val+1 cycles. The first pulse occurs in the first S_RUN cycle.

## Test plan
Defaults (G_NB_RST=4, G_STAGGER=8, G_SYNC_STAGES=2), 1 µs clock.
1. Power-up: rst_n low for 2 cycles, then high.
   -> o_rst_n goes 0000→0001→0011→0111→1111 at 8-cycle spacing, starting 8 cycles after T0.
   -> o_ready rises with bit 3, 32 cycles after T0.
   -> o_clk_en is held high continuously with div_val=0.
2. Divider: div_val=3, then change to 1 mid-period.
   -> o_clk_en pulses every 4 cycles, then every 2 cycles starting from the first wrap after the change.
3. Soft reset: pulse soft_rst_req for 1 cycle in S_RUN.
   -> o_rst_n=0000 and o_ready=0 next cycle.
   -> soft_rst_ack pulses once 9 cycles after the sample.
   -> The release sequence repeats with the same timing as scenario 1.
4. Ignored requests: a req edge during S_RELEASE produces no ack and no effect. A req held high through ack does not retrigger.
5. Hard reset mid-sequence: rst_n low while o_rst_n=0011.
   -> All outputs go to 0 without waiting for a clock edge.
   -> After rst_n goes high, the release sequence restarts from bit 0.
6. Hard reset during S_SOFT_HOLD: no soft_rst_ack is ever emitted, and the normal power-up sequence follows.
